// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter that owns the select input of a shared 4:1 mux.
// Four requesters raise req and hold it while they need the shared path;
// the arbiter issues a registered one-hot grant and the encoded owner index
// that drives the mux select.
//
// Optional feature macro: MUX_ARB_TIMEOUT_EN
//   defined   -> an owner holding the grant for MAX_HOLD cycles is preempted
//                when another requester is waiting (expired pulses once).
//   undefined -> no hold counter; a grant lasts until its owner releases it,
//                and expired is constant 0.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per ownership (2..255)
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset
//   req      in   [3:0] request per requester
//   gnt      out  [3:0] registered one-hot grant, 0 when idle
//   sel      out  [1:0] registered owner index for the mux select
//   busy     out  registered OR of gnt
//   expired  out  registered one-cycle timeout-preemption pulse
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       expired
);

  // Reject out-of-range hold limits at elaboration.
  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
    $error("mux_rr_arbiter: MAX_HOLD must be in 2..255");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Returns {found, index}: first set bit of r searched from p+1 upward
  // (mod 4), with p itself examined last.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = p + 2'(k);
      if (!res[2] && r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

  state_e     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] ptr_q, ptr_d;
  logic       busy_q, busy_d;
  logic       expired_q, expired_d;

  logic [2:0] pick_s;
  logic       take_s;
  logic       drop_s;
  logic [1:0] win_s;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  // The counter reads n-1 during the n-th grant cycle, so reaching this value
  // means the owner has just completed MAX_HOLD cycles.
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    pick_mask_s;
  logic          clr_cnt_s;
  logic          inc_cnt_s;
`endif

  // Normal search starts after the pointer; in GRANT the pointer is the owner,
  // so this is also the release search starting at owner+1.
  assign pick_s = rr_pick(req, ptr_q);

`ifdef MUX_ARB_TIMEOUT_EN
  // Timeout search excludes the current owner.
  assign pick_mask_s = rr_pick(req & ~onehot4(ptr_q), ptr_q);
`endif

  // State and all registered outputs; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'b00;
      ptr_q     <= 2'd3;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      expired_q <= expired_d;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Next-state: decide whether to hand the mux to a new winner, drop to idle,
  // or keep the current owner.
  always_comb begin
    take_s    = 1'b0;
    drop_s    = 1'b0;
    win_s     = 2'b00;
    expired_d = 1'b0;
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
`ifdef MUX_ARB_TIMEOUT_EN
    clr_cnt_s = 1'b0;
    inc_cnt_s = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (pick_s[2]) begin
          take_s = 1'b1;
          win_s  = pick_s[1:0];
        end else begin
          drop_s = 1'b0;
        end
      end
      GRANT: begin
        if (!req[ptr_q]) begin
          // Release: hand over on the same edge if anyone is waiting.
          if (pick_s[2]) begin
            take_s = 1'b1;
            win_s  = pick_s[1:0];
          end else begin
            drop_s = 1'b1;
          end
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
          if (cnt_q == HOLD_LAST) begin
            // Hold limit reached: preempt only if someone else is waiting,
            // otherwise restart the owner's hold window.
            clr_cnt_s = 1'b1;
            if (pick_mask_s[2]) begin
              take_s    = 1'b1;
              win_s     = pick_mask_s[1:0];
              expired_d = 1'b1;
            end else begin
              take_s = 1'b0;
            end
          end else begin
            inc_cnt_s = 1'b1;
          end
`else
          take_s = 1'b0;
`endif
        end
      end
      default: begin
        drop_s = 1'b1;
      end
    endcase

    if (take_s) begin
      state_d = GRANT;
      gnt_d   = onehot4(win_s);
      sel_d   = win_s;
      ptr_d   = win_s;
      busy_d  = 1'b1;
    end else if (drop_s) begin
      // sel and ptr keep the last owner while idle.
      state_d = IDLE;
      gnt_d   = 4'b0000;
      busy_d  = 1'b0;
    end else begin
      state_d = state_q;
    end

`ifdef MUX_ARB_TIMEOUT_EN
    if (take_s || clr_cnt_s) begin
      cnt_d = '0;
    end else if (inc_cnt_s && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
`endif
  end

  // Outputs come straight from registers.
  always_comb begin
    gnt     = gnt_q;
    sel     = sel_q;
    busy    = busy_q;
    expired = expired_q;
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  localparam int MAXH = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       expired;

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 when nobody holds the mux), last owner
  // for round-robin, select value, grant cycles completed, timeout pulse.
  int m_owner;
  int m_last;
  int m_sel;
  int m_cnt;
  bit m_exp;

  mux_rr_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .expired (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int after);
    for (int k = 1; k <= 4; k++) begin
      int idx;
      idx = (after + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic rst_ok, input logic [3:0] r);
    int w;
    m_exp = 1'b0;
    if (!rst_ok) begin
      m_owner = -1; m_last = 3; m_sel = 0; m_cnt = 0;
    end else if (m_owner < 0) begin
      w = pick(r, m_last);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_sel = w; m_cnt = 0;
      end
    end else if (!r[m_owner]) begin
      w = pick(r, m_owner);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_sel = w; m_cnt = 0;
      end else begin
        m_owner = -1;
      end
    end else begin
      m_cnt++;
`ifdef MUX_ARB_TIMEOUT_EN
      if (m_cnt == MAXH) begin
        logic [3:0] others;
        others = r & ~(4'b0001 << m_owner);
        w = pick(others, m_owner);
        m_cnt = 0;
        if (w >= 0) begin
          m_owner = w; m_last = w; m_sel = w; m_exp = 1'b1;
        end
      end
`endif
    end
  endtask

  function automatic logic [7:0] model_out();
    logic [3:0] g;
    g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    return {g, 2'(m_sel), (m_owner >= 0), m_exp};
  endfunction

  // One clock: model samples the same inputs the DUT sees, then compare.
  task automatic step();
    @(posedge clk);
    model_edge(rst_n, req);
    #1;
    check_val("outputs", {gnt, sel, busy, expired}, model_out());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    m_owner = -1; m_last = 3; m_sel = 0; m_cnt = 0; m_exp = 1'b0;

    // Reset held 3 cycles with all requests raised.
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_gnt", {4'b0, gnt}, 8'h00);
      check_val("rst_sel_busy", {5'b0, sel, busy}, 8'h00);
    end
    rst_n = 1'b1;
    step();
    check_val("first_gnt", {4'b0, gnt}, 8'h01);

    // Single requester.
    req = 4'b0000;
    step();
    req = 4'b0100;
    step();
    check_val("single_gnt", {4'b0, gnt}, 8'h04);
    check_val("single_sel", {6'b0, sel}, 8'h02);
    check_val("single_busy", {7'b0, busy}, 8'h01);
    req = 4'b0000;
    step();
    check_val("single_rel_gnt", {4'b0, gnt}, 8'h00);
    check_val("single_rel_busy", {7'b0, busy}, 8'h00);
    check_val("single_rel_sel", {6'b0, sel}, 8'h02);

    // Rotation with back-to-back handover.
    do_reset();
    req = 4'b1111;
    step();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] expg;
      expg = 8'h01 << (i % 4);
      check_val("rot_gnt", {4'b0, gnt}, expg);
      check_val("rot_busy", {7'b0, busy}, 8'h01);
      step();
      step();
      req[i % 4] = 1'b0;
      step();
      req[i % 4] = 1'b1;
    end

    // Fairness: owner 1 releases with 0,1,3 requesting -> 3, then 0.
    do_reset();
    req = 4'b0010;
    step();
    req = 4'b1011;
    step();
    check_val("fair_own1", {4'b0, gnt}, 8'h02);
    req = 4'b1001;
    step();
    check_val("fair_gnt3", {4'b0, gnt}, 8'h08);
    check_val("fair_sel3", {6'b0, sel}, 8'h03);
    req = 4'b0001;
    step();
    check_val("fair_gnt0", {4'b0, gnt}, 8'h01);

    // Timeout with a competing requester.
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b0101;
    for (int i = 1; i <= 7; i++) begin
      step();
      check_val("to_hold", {4'b0, gnt}, 8'h01);
    end
    step();
`ifdef MUX_ARB_TIMEOUT_EN
    check_val("to_preempt_gnt", {4'b0, gnt}, 8'h04);
    check_val("to_expired", {7'b0, expired}, 8'h01);
    step();
    check_val("to_expired_pulse", {7'b0, expired}, 8'h00);
`else
    for (int i = 0; i < 20; i++) begin
      check_val("noto_gnt", {4'b0, gnt}, 8'h01);
      check_val("noto_expired", {7'b0, expired}, 8'h00);
      step();
    end
`endif

    // Lone requester keeps the grant indefinitely.
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 24; i++) begin
      step();
      check_val("lone_gnt", {4'b0, gnt}, 8'h01);
      check_val("lone_expired", {7'b0, expired}, 8'h00);
    end

    // Mid-grant reset.
    do_reset();
    req = 4'b1111;
    step();
    req = 4'b1110;
    step();
    check_val("mid_own1", {4'b0, gnt}, 8'h02);
    req = 4'b1111;
    rst_n = 1'b0;
    step();
    check_val("mid_rst_gnt", {4'b0, gnt}, 8'h00);
    rst_n = 1'b1;
    step();
    check_val("mid_next_gnt", {4'b0, gnt}, 8'h01);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      rst_n = ($urandom_range(0, 63) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
